branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Control-transfer sequencer for the SPARC8 pipeline. Sits in ID, between decode and the PC/nPC logic.
- Evaluates Bicc conditions against the Program Status Register flags.
- Stalls one cycle when the instruction in EX is about to write the PSR.
- Selects the next-PC source and applies SPARC annul semantics to the delay slot.
- Keeps a saturating count of taken conditional branches for debug.

Parameters:
- CNT_W, 8, width of the taken-branch counter Taken_Cnt.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Clr  in  1  reset, synchronous, active-high.
- ID_B_Instr  in  1  Bicc instruction in ID.
- ID_Call  in  1  CALL instruction in ID.
- ID_Jmpl  in  1  JMPL instruction in ID.
- I29_a  in  1  annul bit of the Bicc in ID.
- I28_25  in  4  Bicc cond field.
- PSR_Out  in  4  current flags {Z,N,C,V}.
- EX_LE  in  1  instruction in EX writes the PSR at the next edge.
- Stall_In  in  1  external pipeline stall (e.g. memory wait).
- PC_Sel  out  2  next-PC source: 00 sequential nPC, 01 branch target, 10 call target, 11 jmpl target.
- Annul  out  1  squash the delay-slot instruction now in IF (becomes a nop at the next edge).
- CC_Stall  out  1  hold IF/ID for one cycle because of a condition-code hazard.
- Taken_Cnt  out  CNT_W  number of taken Bicc, saturating.

Behaviour:
- State register: RUN, CC_WAIT, DELAY. PC_Sel, Annul and CC_Stall are combinational from state and inputs (Mealy). Taken_Cnt is registered.
- Condition eval, Z=PSR_Out[3], N=[2], C=[1], V=[0]:
  - 1000 always, 0000 never
  - 1001 !Z, 0001 Z
  - 1010 !(Z|(N^V)), 0010 Z|(N^V)
  - 1011 !(N^V), 0011 N^V
  - 1100 !(C|Z), 0100 C|Z
  - 1101 !C, 0101 C
  - 1110 !N, 0110 N
  - 1111 !V, 0111 V
- Decode priority when several decode inputs are high: ID_Jmpl > ID_Call > ID_B_Instr.
- RUN:
  - Jmpl: PC_Sel=11, Annul=0, next DELAY.
  - Call: PC_Sel=10, Annul=0, next DELAY.
  - Bicc with EX_LE=1 and cond not 1000/0000: CC_Stall=1, PC_Sel=00, Annul=0, next CC_WAIT.
  - Bicc otherwise: resolve this cycle (rules below), next DELAY.
  - No decode input high: all outputs 0, stay RUN.
- CC_WAIT:
  - CC_Stall=0; decode inputs are still held by the stall.
  - Resolve the Bicc against the updated PSR_Out, regardless of EX_LE; next DELAY.
- Resolve rules:
  - taken → PC_Sel=01; not taken → PC_Sel=00.
  - Annul = I29_a & (!taken | cond==1000). So BA,a annuls; taken conditional with a=1 executes the slot; a=0 never annuls.
  - If taken, Taken_Cnt increments at the next edge, saturating at 2^CNT_W-1. CALL/JMPL never count.
- DELAY:
  - Delay-slot instruction is in ID. Any decode input is ignored: PC_Sel=00, Annul=0, CC_Stall=0, no count.
  - Next RUN.
- Stall_In=1 (any state): state and Taken_Cnt hold; PC_Sel=00, Annul=0, CC_Stall=0. Resolution happens in the first cycle with Stall_In=0.
- Clr=1 at an edge: state←RUN, Taken_Cnt←0, from any state including CC_WAIT/DELAY.
- While Clr=1 all combinational outputs are forced 0. Clr has priority over Stall_In.

Test Plan:
- Clr, then BA (1000), a=0, EX_LE=0 → same cycle PC_Sel=01, Annul=0; Taken_Cnt 0→1 at next edge; next cycle BNE with PSR=0000 in DELAY → PC_Sel=00, count stays 1.
- BE (0001), a=1, PSR=0000 → PC_Sel=00, Annul=1, count unchanged. BCS (0101), a=1, PSR=0010 → PC_Sel=01, Annul=0. BA, a=1 → PC_Sel=01, Annul=1.
- BNE (1001), EX_LE=1, PSR=1000 at cycle t → CC_Stall=1, PC_Sel=00. Cycle t+1 with PSR=0000 → CC_Stall=0, PC_Sel=01, count +1.
- ID_Jmpl=ID_Call=ID_B_Instr=1 with cond=1000 → PC_Sel=11, Annul=0, count unchanged. ID_Call alone → PC_Sel=10.
- BG (1010), PSR=0000, Stall_In=1 for 3 cycles → outputs 0 and count held. Stall_In=0 → PC_Sel=01, then DELAY.
- CNT_W=2, five taken BA → Taken_Cnt=3 (saturated). Clr asserted while in DELAY → next cycle state RUN, Taken_Cnt=0, and a fresh BA resolves immediately.

Source files
------------

// File: rtl/branch_sequencer.sv
// branch_sequencer: Bicc/CALL/JMPL next-PC selection with condition-code
// hazard stall, SPARC delay-slot annulment and a saturating taken-branch count.
module branch_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             ID_B_Instr,
   input  logic             ID_Call,
   input  logic             ID_Jmpl,
   input  logic             I29_a,
   input  logic [3:0]       I28_25,
   input  logic [3:0]       PSR_Out,
   input  logic             EX_LE,
   input  logic             Stall_In,
   output logic [1:0]       PC_Sel,
   output logic             Annul,
   output logic             CC_Stall,
   output logic [CNT_W-1:0] Taken_Cnt
);
   typedef enum logic [1:0] {RUN, CC_WAIT, DELAY} state_t;
   state_t state, nxt;
   logic base, taken, always_c, inc;
   // Low three bits pick the flag expression; cond[3] inverts it.
   always_comb begin
      base = 1'b0;
      case (I28_25[2:0])
         3'd1: base = PSR_Out[3];
         3'd2: base = PSR_Out[3] | (PSR_Out[2] ^ PSR_Out[0]);
         3'd3: base = PSR_Out[2] ^ PSR_Out[0];
         3'd4: base = PSR_Out[1] | PSR_Out[3];
         3'd5: base = PSR_Out[1];
         3'd6: base = PSR_Out[2];
         3'd7: base = PSR_Out[0];
         default: base = 1'b0;
      endcase
      taken = base ^ I28_25[3];
      always_c = I28_25[2:0] == 3'd0;
   end
   always_comb begin
      PC_Sel = 2'b00;
      Annul = 1'b0;
      CC_Stall = 1'b0;
      inc = 1'b0;
      nxt = state;
      if (!Clr && !Stall_In) begin
         case (state)
            DELAY: nxt = RUN;
            CC_WAIT: begin
               PC_Sel = taken ? 2'b01 : 2'b00;
               Annul = I29_a & (!taken | I28_25 == 4'b1000);
               inc = taken;
               nxt = DELAY;
            end
            default: begin
               if (ID_Jmpl) begin
                  PC_Sel = 2'b11;
                  nxt = DELAY;
               end else if (ID_Call) begin
                  PC_Sel = 2'b10;
                  nxt = DELAY;
               end else if (ID_B_Instr) begin
                  if (EX_LE && !always_c) begin
                     CC_Stall = 1'b1;
                     nxt = CC_WAIT;
                  end else begin
                     PC_Sel = taken ? 2'b01 : 2'b00;
                     Annul = I29_a & (!taken | I28_25 == 4'b1000);
                     inc = taken;
                     nxt = DELAY;
                  end
               end
            end
         endcase
      end
   end
   always_ff @(posedge Clk) begin
      if (Clr) begin
         state <= RUN;
         Taken_Cnt <= '0;
      end else begin
         state <= nxt;
         if (inc && Taken_Cnt != {CNT_W{1'b1}}) Taken_Cnt <= Taken_Cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed and randomized checks of branch_sequencer
// against a behavioural model of the sequencing and condition rules.
module tb_branch_sequencer;
   localparam int W = 2;
   localparam int SAT = (1 << W) - 1;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic clr, b, call, jmpl, a, exle, stall;
   logic [3:0] cond, psr;
   logic [1:0] pc;
   logic an, st;
   logic [W-1:0] cnt;
   int checks = 0, failures = 0;
   int m_state = 0, m_next = 0, m_cnt = 0;
   logic [1:0] e_pc;
   logic e_an, e_st, e_inc;

   branch_sequencer #(.CNT_W(W)) dut (
      .Clk(clk), .Clr(clr), .ID_B_Instr(b), .ID_Call(call), .ID_Jmpl(jmpl),
      .I29_a(a), .I28_25(cond), .PSR_Out(psr), .EX_LE(exle), .Stall_In(stall),
      .PC_Sel(pc), .Annul(an), .CC_Stall(st), .Taken_Cnt(cnt)
   );

   function automatic bit m_cond(input logic [3:0] c, input logic [3:0] p);
      bit z, n, cy, v;
      {z, n, cy, v} = p;
      case (c)
         4'b1000: return 1'b1;
         4'b0000: return 1'b0;
         4'b1001: return !z;
         4'b0001: return z;
         4'b1010: return !(z || (n != v));
         4'b0010: return z || (n != v);
         4'b1011: return n == v;
         4'b0011: return n != v;
         4'b1100: return !(cy || z);
         4'b0100: return cy || z;
         4'b1101: return !cy;
         4'b0101: return cy;
         4'b1110: return !n;
         4'b0110: return n;
         4'b1111: return !v;
         default: return v;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // mode 0: free to decode, 1: waiting on the PSR write, 2: delay slot in ID
   task automatic model();
      bit t;
      e_pc = 0; e_an = 0; e_st = 0; e_inc = 0; m_next = m_state;
      t = m_cond(cond, psr);
      if (clr) m_next = 0;
      else if (stall) m_next = m_state;
      else if (m_state == 2) m_next = 0;
      else if (m_state == 1 || (!jmpl && !call && b && !(exle && cond != 4'b1000 && cond != 4'b0000))) begin
         e_pc = t ? 2'd1 : 2'd0;
         e_an = a && (!t || cond == 4'b1000);
         e_inc = t;
         m_next = 2;
      end else if (jmpl) begin
         e_pc = 2'd3; m_next = 2;
      end else if (call) begin
         e_pc = 2'd2; m_next = 2;
      end else if (b) begin
         e_st = 1; m_next = 1;
      end
   endtask

   task automatic drive(input logic i_clr, input logic i_b, input logic i_call, input logic i_jmpl,
                        input logic i_a, input logic [3:0] i_cond, input logic [3:0] i_psr,
                        input logic i_exle, input logic i_stall);
      clr = i_clr; b = i_b; call = i_call; jmpl = i_jmpl; a = i_a;
      cond = i_cond; psr = i_psr; exle = i_exle; stall = i_stall;
      #1;
      model();
      chk("pc_sel", 32'(pc), 32'(e_pc));
      chk("annul", 32'(an), 32'(e_an));
      chk("cc_stall", 32'(st), 32'(e_st));
   endtask

   task automatic tick();
      @(posedge clk);
      if (clr) m_cnt = 0;
      else if (e_inc && m_cnt < SAT) m_cnt++;
      m_state = m_next;
      #1;
      chk("taken_cnt", 32'(cnt), 32'(m_cnt));
      @(negedge clk);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
      tick();
   endtask

   initial begin
      clr = 1; b = 0; call = 0; jmpl = 0; a = 0; cond = 0; psr = 0; exle = 0; stall = 0;
      @(negedge clk);
      drive(1, 1, 1, 1, 1, 4'b1000, 4'h0, 0, 0);
      chk("clr_forces_pc0", 32'(pc), 0);
      tick();
      chk("reset_cnt", 32'(cnt), 0);
      drive(0, 1, 0, 0, 0, 4'b1000, 4'h0, 0, 0);
      chk("ba_pc", 32'(pc), 1);
      chk("ba_annul", 32'(an), 0);
      tick();
      chk("ba_cnt", 32'(cnt), 1);
      drive(0, 1, 0, 0, 0, 4'b1001, 4'h0, 0, 0);
      chk("delay_ignores_bne", 32'(pc), 0);
      tick();
      chk("delay_no_count", 32'(cnt), 1);
      drive(0, 1, 0, 0, 1, 4'b0001, 4'h0, 0, 0);
      chk("be_nt_pc", 32'(pc), 0);
      chk("be_nt_annul", 32'(an), 1);
      tick(); idle();
      drive(0, 1, 0, 0, 1, 4'b0101, 4'b0010, 0, 0);
      chk("bcs_pc", 32'(pc), 1);
      chk("bcs_annul", 32'(an), 0);
      tick(); idle();
      drive(0, 1, 0, 0, 1, 4'b1000, 4'h0, 0, 0);
      chk("ba_a_pc", 32'(pc), 1);
      chk("ba_a_annul", 32'(an), 1);
      tick(); idle();
      drive(0, 1, 0, 0, 0, 4'b1001, 4'b1000, 1, 0);
      chk("hazard_stall", 32'(st), 1);
      chk("hazard_pc", 32'(pc), 0);
      tick();
      drive(0, 1, 0, 0, 0, 4'b1001, 4'b0000, 1, 0);
      chk("ccwait_stall", 32'(st), 0);
      chk("ccwait_pc", 32'(pc), 1);
      tick(); idle();
      drive(0, 1, 1, 1, 0, 4'b1000, 4'h0, 0, 0);
      chk("jmpl_prio_pc", 32'(pc), 3);
      tick(); idle();
      drive(0, 0, 1, 0, 0, 4'b1000, 4'h0, 0, 0);
      chk("call_pc", 32'(pc), 2);
      tick(); idle();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0, 4'b1010, 4'h0, 0, 1);
         chk("stall_pc", 32'(pc), 0);
         tick();
      end
      drive(0, 1, 0, 0, 0, 4'b1010, 4'h0, 0, 0);
      chk("bg_after_stall", 32'(pc), 1);
      tick(); idle();
      chk("saturated", 32'(cnt), SAT);
      drive(0, 1, 0, 0, 0, 4'b1000, 4'h0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
      tick();
      chk("clr_in_delay", 32'(cnt), 0);
      drive(0, 1, 0, 0, 0, 4'b1000, 4'h0, 0, 0);
      chk("fresh_ba", 32'(pc), 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         idle();
         drive(0, 1, 0, 0, 0, 4'b1000, 4'h0, 0, 0);
         tick();
      end
      chk("five_ba_sat", 32'(cnt), SAT);
      for (int i = 0; i < 500; i++) begin
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
               $urandom_range(0, 5) == 0, 1'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom), $urandom_range(0, 4) == 0);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
